// File: rtl/pwm_dac_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// pwm_dac_multi : multi-channel PWM DAC, boundary-latched duty, noise shaping
// Rev 1.0
// ----------------------------------------------------------------------------
module pwm_dac_multi #(
  parameter int SIGNALWIDTH = 16,
  parameter int PWMWIDTH    = 6,
  parameter int CHANNELS    = 2,
  parameter int NOISESHAPE  = 1,
  parameter int STAGGER     = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [CHANNELS*SIGNALWIDTH-1:0] d,
  output logic [CHANNELS-1:0]             ack,
  output logic [CHANNELS-1:0]             q
);

  localparam int FW      = SIGNALWIDTH - PWMWIDTH;
  localparam int PERIOD  = 2 ** PWMWIDTH;
  localparam int OFFSTEP = PERIOD / CHANNELS;

  logic [PWMWIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!enable) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PWMWIDTH'(1);
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    localparam int                  OFF_INT = (STAGGER != 0) ? ch * OFFSTEP : 0;
    localparam logic [PWMWIDTH-1:0] OFF     = PWMWIDTH'(OFF_INT);

    logic [PWMWIDTH-1:0] ph;
    logic [PWMWIDTH-1:0] coarse;
    logic [FW-1:0]       fine;
    logic [FW:0]         sum;
    logic                carry;
    logic                latch;
    logic [FW-1:0]       acc_q, acc_d;
    logic [PWMWIDTH:0]   duty_q, duty_d;
    logic                q_q, ack_q;

    assign ph     = cnt_q + OFF;
    assign coarse = d[ch*SIGNALWIDTH + FW +: PWMWIDTH];
    assign fine   = d[ch*SIGNALWIDTH +: FW];
    assign latch  = enable && (ph == {PWMWIDTH{1'b1}});
    assign sum    = {1'b0, acc_q} + {1'b0, fine};

    if (NOISESHAPE != 0) begin : g_ns
      assign carry = sum[FW];
      assign acc_d = sum[FW-1:0];
    end else begin : g_trunc
      assign carry = 1'b0;
      assign acc_d = '0;
    end

    // coarse is at most 2^P-1, so adding the carry reaches full scale without wrapping
    assign duty_d = {1'b0, coarse} + {{PWMWIDTH{1'b0}}, carry};

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc_q  <= '0;
        duty_q <= '0;
        q_q    <= 1'b0;
        ack_q  <= 1'b0;
      end else if (!enable) begin
        acc_q  <= '0;
        duty_q <= '0;
        q_q    <= 1'b0;
        ack_q  <= 1'b0;
      end else begin
        ack_q <= latch;
        q_q   <= ({1'b0, ph} < duty_q);
        if (latch) begin
          duty_q <= duty_d;
          acc_q  <= acc_d;
        end
      end
    end

    assign q[ch]   = q_q;
    assign ack[ch] = ack_q;
  end

endmodule
`default_nettype wire
